// File: rtl/serial_negate_if.sv
// Operand/result handshake bundle for the bit-serial negation unit.
// The master side supplies operands and consumes results; the slave side is the unit.
interface serial_negate_if #(
  parameter int size = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [size-1:0] a;
  logic            out_valid;
  logic            out_ready;
  logic [size-1:0] r;
  logic            busy;

  modport master (
    output in_valid, a, out_ready,
    input  in_ready, out_valid, r, busy
  );

  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, out_valid, r, busy
  );
endinterface

// File: rtl/serial_negate.sv
// Bit-serial two's-complement negation: copy bits up to the first 1, invert the rest.
// Optional overflow flag (operand is the most negative value) enabled by SERIAL_NEGATE_OVF_EN.
module serial_negate #(
  parameter int size = 16
) (
  input  logic                clk,
  input  logic                rst,
  serial_negate_if.slave      bus
`ifdef SERIAL_NEGATE_OVF_EN
  ,
  output logic                ovf
`endif
);

  localparam int cw = $clog2(size);
  localparam logic [cw-1:0] last = cw'(size - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]      state;
  logic [size-1:0] sreg;
  logic [size-1:0] r_q;
  logic [cw-1:0]   cnt;
  logic            seen_one;
  logic            out_bit;

  // The operand drains out of bit 0 while the result fills in from the top,
  // so after size shifts the same register holds -a in natural order.
  assign out_bit = seen_one ? ~sreg[0] : sreg[0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain sreg/seen_one/r_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sreg     <= '0;
      r_q      <= '0;
      cnt      <= '0;
      seen_one <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sreg     <= bus.a;
            cnt      <= '0;
            seen_one <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          sreg     <= {out_bit, sreg[size-1:1]};
          seen_one <= seen_one | sreg[0];
          cnt      <= cnt + cw'(1);
          if (cnt == last) begin
            r_q   <= {out_bit, sreg[size-1:1]};
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_NEGATE_OVF_EN
  // Last bit is 1 with no earlier 1: the operand is 100...0, which negates to itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (state == SHIFT && cnt == last) begin
      ovf <= sreg[0] & ~seen_one;
    end else if (state == DONE && bus.out_ready) begin
      ovf <= 1'b0;
    end
  end
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.r         = r_q;

endmodule

// File: tb/tb_serial_negate.sv
// Self-checking bench for serial_negate; reference is modular arithmetic negation.
// Overflow checks are compiled in when SERIAL_NEGATE_OVF_EN is defined.
module tb_serial_negate;

  localparam int size = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ovf;
  int   passed = 0;
  int   total  = 0;

  serial_negate_if #(.size(size)) bus ();

`ifdef SERIAL_NEGATE_OVF_EN
  serial_negate #(.size(size)) dut (.clk(clk), .rst(rst), .bus(bus), .ovf(ovf));
`else
  serial_negate #(.size(size)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic logic [15:0] neg(input logic [15:0] x);
    int unsigned v;
    v = (32'd65536 - 32'(x)) % 32'd65536;
    return v[15:0];
  endfunction

  // Accepts one operand, returns cycles from accept edge to out_valid and r.
  task automatic send(input logic [15:0] val, output int lat, output logic [15:0] res);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    bus.a = val;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = 16'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    res = bus.r;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else passed++;
    total++; if (bus.r !== 16'h0000) $display("FAIL reset_r got=%h exp=0000", bus.r); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", ovf); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat;
    logic [15:0] res;
    bus.out_ready = 1'b1;
    send(16'h00F8, lat, res);
    total++; if (lat !== 16) $display("FAIL basic_latency got=%0d exp=16", lat); else passed++;
    total++; if (res !== 16'hFF08) $display("FAIL basic_r got=%h exp=ff08", res); else passed++;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL basic_exclusive in_ready=%b exp=0", bus.in_ready); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL basic_ovf got=%b exp=0", ovf); else passed++;
    @(posedge clk); #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL basic_ready_after got=%b exp=1", bus.in_ready); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL basic_valid_after got=%b exp=0", bus.out_valid); else passed++;
  endtask

  task automatic test_edges;
    logic [15:0] ops [5] = '{16'h0001, 16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    int lat;
    logic [15:0] res;
    bus.out_ready = 1'b1;
    foreach (ops[i]) begin
      send(ops[i], lat, res);
      total++; if (res !== neg(ops[i])) $display("FAIL edge_r a=%h got=%h exp=%h", ops[i], res, neg(ops[i])); else passed++;
`ifdef SERIAL_NEGATE_OVF_EN
      total++;
      if (ovf !== (ops[i] == 16'h8000)) $display("FAIL edge_ovf a=%h got=%b exp=%b", ops[i], ovf, ops[i] == 16'h8000);
      else passed++;
`endif
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random;
    logic [15:0] val;
    int lat;
    logic [15:0] res;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      val = 16'($urandom);
      send(val, lat, res);
      total++; if (lat !== 16 || res !== neg(val)) $display("FAIL random a=%h got=%h lat=%0d exp=%h lat=16", val, res, lat, neg(val)); else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] val, held;
    int lat;
    logic [15:0] res;
    val = 16'($urandom) | 16'h0010;
    bus.out_ready = 1'b0;
    send(val, lat, res);
    held = res;
    total++; if (res !== neg(val)) $display("FAIL bp_r got=%h exp=%h", res, neg(val)); else passed++;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.a = 16'($urandom);
      @(posedge clk); #1;
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.r !== held)
        $display("FAIL bp_hold cyc=%0d got v=%b rdy=%b r=%h exp v=1 rdy=0 r=%h", i, bus.out_valid, bus.in_ready, bus.r, held);
      else passed++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release got=%b exp=1", bus.in_ready); else passed++;
    val = 16'($urandom);
    send(val, lat, res);
    total++; if (res !== neg(val)) $display("FAIL bp_next got=%h exp=%h", res, neg(val)); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [15:0] res;
    bus.out_ready = 1'b1;
    bus.a = 16'h5A5A;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.r !== 16'h0000 || bus.busy !== 1'b0 || ovf !== 1'b0)
      $display("FAIL midreset got rdy=%b v=%b r=%h busy=%b ovf=%b exp 1 0 0000 0 0", bus.in_ready, bus.out_valid, bus.r, bus.busy, ovf);
    else passed++;
    send(16'h1234, lat, res);
    total++; if (res !== 16'hEDCC || lat !== 16) $display("FAIL midreset_next got=%h lat=%0d exp=edcc lat=16", res, lat); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int cyc, nacc, nres;
    int t_acc [2];
    logic [15:0] res [2];
    logic acc;
    cyc = 0; nacc = 0; nres = 0;
    bus.out_ready = 1'b1;
    bus.a = 16'h0003;
    bus.in_valid = 1'b1;
    while (nres < 2 && cyc < 100) begin
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc && nacc < 2) begin
        t_acc[nacc] = cyc;
        nacc++;
        bus.a = 16'hFFFF;
      end
      if (bus.out_valid) begin
        res[nres] = bus.r;
        nres++;
        if (nres == 2) bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    total++; if (nres !== 2 || nacc !== 2) $display("FAIL b2b_timeout results=%0d accepts=%0d exp=2", nres, nacc); else passed++;
    if (nres == 2 && nacc == 2) begin
      total++; if (res[0] !== neg(16'h0003)) $display("FAIL b2b_r0 got=%h exp=%h", res[0], neg(16'h0003)); else passed++;
      total++; if (res[1] !== neg(16'hFFFF)) $display("FAIL b2b_r1 got=%h exp=%h", res[1], neg(16'hFFFF)); else passed++;
      total++; if (t_acc[1] - t_acc[0] !== 18) $display("FAIL b2b_spacing got=%0d exp=18", t_acc[1] - t_acc[0]); else passed++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.out_ready = 1'b0;
    test_reset;
    test_basic;
    test_edges;
    test_random;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serial_negate.md
# serial_negate

Bit-serial two's-complement negation unit for the ALU datapath. It accepts a `size`-bit operand over a valid/ready handshake and produces `-a`, computed one bit per clock, LSB first, with the rule "copy up to and including the first 1, invert every bit above it". It is the arithmetic counterpart of the bitwise inverter: it consumes the inverted form plus the +1 carry, without a full-width adder. It sits between the operand register and the ALU result mux.

## Interface
- `size`, 16, operand/result width in bits (≥2)
- `clk` input 1 — sole clock, rising edge
- `rst` input 1 — synchronous, active-high reset
- `in_valid` input 1 — operand `a` valid
- `in_ready` output 1 — unit can accept an operand
- `a` input `size` — operand, sampled only on the accept edge
- `out_valid` output 1 — result `r` valid
- `out_ready` input 1 — consumer takes `r`
- `r` output `size` — negated result
- `busy` output 1 — high in SHIFT or DONE
- `ovf` output 1 — overflow flag (present only with `SERIAL_NEGATE_OVF_EN`)

## Operation
- States: IDLE, SHIFT, DONE. Encoding is free.
- IDLE: `in_ready`=1. When `in_valid`&&`in_ready` at an edge (accept):
  - load `a` into the shift register
  - clear bit counter and the `seen_one` flag
  - go to SHIFT
- SHIFT: each edge processes bit `cnt`:
  - `out_bit` = `seen_one` ? ~bit : bit
  - `seen_one` |= bit
  - shift the result in MSB-first-filled so the final word is in natural order
  - `cnt`++
  - on the edge where `cnt`==`size`-1, go to DONE
- DONE: `out_valid`=1 and `r` stable. When `out_ready` is high at an edge, go to IDLE.
- `r` holds its last value in IDLE and SHIFT. It is updated only on the SHIFT→DONE edge.
- Ignored inputs:
  - `in_valid` outside IDLE
  - `out_ready` outside DONE
- Arithmetic is modulo 2^`size`:
  - 0 → 0
  - 0x8000 (most negative value) → 0x8000
- Reset (at any state, including mid-SHIFT):
  - next state IDLE; partial result discarded
  - `in_ready`=1
  - `out_valid`=0, `busy`=0, `r`=0, `ovf`=0
  - counter and `seen_one` cleared
- Reset wins over a simultaneous accept or output handshake.

## Timing
- Accept at edge E0 → SHIFT from E0 through E0+`size`-1 (`size` bit-edges) → DONE visible after edge E0+`size`.
- Latency: `out_valid` rises `size` cycles after the accept edge.
- Handshake timing:
  - if `out_ready` is already high when `out_valid` rises, the handshake occurs at the next edge and `in_ready` is high after it
  - next accept no earlier than the following edge
  - minimum accept-to-accept period is `size`+2 cycles
- `in_ready` and `out_valid` are mutually exclusive and never both high.
- All outputs are registered or state-decoded. No combinational path from inputs to outputs.

## Configuration
- `SERIAL_NEGATE_OVF_EN` defined:
  - `ovf` port exists
  - set on the SHIFT→DONE edge iff operand == 1 followed by `size`-1 zeros (i.e. 0x8000 for `size`=16)
  - held through DONE, cleared on leaving DONE and on reset
- Not defined: no `ovf` port and no overflow logic. All other behaviour is identical.

## Test plan
- Reset, then `a`=0x00F8 (248) accepted with `out_ready`=1 → `out_valid` exactly 16 cycles after accept, `r`=0xFF08, `ovf`=0, `in_ready` high 1 cycle later.
- `a`=0x0001 → `r`=0xFFFF; `a`=0x0000 → `r`=0x0000 (`seen_one` never set, no inversion).
- With `SERIAL_NEGATE_OVF_EN`, `a`=0x8000 → `r`=0x8000, `ovf`=1; next operand 0x7FFF → `r`=0x8001, `ovf`=0.
- Backpressure: `out_ready`=0 for 5 cycles after `out_valid` → `r` and `out_valid` stable, `in_ready`=0, and `in_valid` with a new `a` is ignored. Releasing `out_ready` completes the handshake and the next accept yields the correct result.
- `rst` asserted 7 cycles into SHIFT → next cycle IDLE, `out_valid`=0, `r`=0, `busy`=0. A fresh `a`=0x1234 then gives `r`=0xEDCC.
- Back-to-back operands 0x0003, 0xFFFF with `in_valid` and `out_ready` held high → `r`=0xFFFD then 0x0001, accept spacing 18 cycles.
